vm_order_entry: RTL



---
 rtl/vm_order_entry.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vm_order_entry.sv
// Order-entry front end for the combinational vendingmachine core: collects coin credit,
// latches a selection, samples the core verdict, then dispenses or refunds. Optional VM_TIMEOUT_EN.
module vm_order_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_sel,
    input  logic       sel_valid,
    input  logic [1:0] sel_code,
    input  logic [2:0] sel_count,
    input  logic       cancel,
    output logic [1:0] vm_code,
    output logic [2:0] vm_count,
    output logic [3:0] vm_money,
    input  logic       vm_posibility,
    input  logic [3:0] vm_remaining,
    output logic       coin_reject,
    output logic       sel_fail,
    output logic       dispense_valid,
    output logic [1:0] dispense_code,
    output logic [2:0] dispense_count,
    output logic       change_valid,
    output logic [3:0] change,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_EVAL,
        S_DISPENSE,
        S_REFUND
    } state_t;

    state_t     r_state;
    logic [3:0] r_credit;
    logic [1:0] r_code;
    logic [2:0] r_count;
    logic       r_coin_reject;
    logic       r_sel_fail;
    logic       r_disp_valid;
    logic [1:0] r_disp_code;
    logic [2:0] r_disp_count;
    logic       r_change_valid;
    logic [3:0] r_change;
    logic       r_busy;

    logic [3:0] w_coin_val;
    logic [4:0] w_sum;
    logic       w_coin_ok;

`ifdef VM_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] r_tmo;
`endif

    always_comb begin
        w_coin_val = 4'd1;
        case (coin_sel)
            2'd0: w_coin_val = 4'd1;
            2'd1: w_coin_val = 4'd2;
            2'd2: w_coin_val = 4'd5;
            2'd3: w_coin_val = 4'd10;
            default: w_coin_val = 4'd1;
        endcase
    end

    // Carry bit flags a sum above 15: such a coin is bounced rather than wrapping credit.
    assign w_sum     = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_ok = coin_valid && !w_sum[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_code         <= '0;
            r_count        <= '0;
            r_coin_reject  <= 1'b0;
            r_sel_fail     <= 1'b0;
            r_disp_valid   <= 1'b0;
            r_disp_code    <= '0;
            r_disp_count   <= '0;
            r_change_valid <= 1'b0;
            r_change       <= '0;
            r_busy         <= 1'b0;
`ifdef VM_TIMEOUT_EN
            r_tmo          <= '0;
`endif
        end else begin
            r_coin_reject  <= 1'b0;
            r_sel_fail     <= 1'b0;
            r_disp_valid   <= 1'b0;
            r_disp_code    <= '0;
            r_disp_count   <= '0;
            r_change_valid <= 1'b0;
            r_change       <= '0;
`ifdef VM_TIMEOUT_EN
            r_tmo          <= '0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (coin_valid) begin
                        r_credit <= w_sum[3:0];
                        r_state  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (cancel) begin
                        r_coin_reject  <= coin_valid;
                        r_change_valid <= (r_credit != '0);
                        r_change       <= r_credit;
                        r_busy         <= 1'b1;
                        r_state        <= S_REFUND;
                    end else begin
                        if (coin_valid) begin
                            if (w_sum[4]) r_coin_reject <= 1'b1;
                            else          r_credit      <= w_sum[3:0];
                        end
                        if (sel_valid && sel_count != '0) begin
                            r_code  <= sel_code;
                            r_count <= sel_count;
                            r_busy  <= 1'b1;
                            r_state <= S_EVAL;
                        end
`ifdef VM_TIMEOUT_EN
                        else if (!w_coin_ok) begin
                            if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                                r_change_valid <= (r_credit != '0);
                                r_change       <= r_credit;
                                r_busy         <= 1'b1;
                                r_state        <= S_REFUND;
                            end else begin
                                r_tmo <= r_tmo + 1'b1;
                            end
                        end
`endif
                    end
                end
                S_EVAL: begin
                    r_coin_reject <= coin_valid;
                    if (vm_posibility) begin
                        r_disp_valid   <= 1'b1;
                        r_disp_code    <= r_code;
                        r_disp_count   <= r_count;
                        r_change_valid <= (vm_remaining != '0);
                        r_change       <= vm_remaining;
                        r_state        <= S_DISPENSE;
                    end else begin
                        r_sel_fail <= 1'b1;
                        r_code     <= '0;
                        r_count    <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_COLLECT;
                    end
                end
                S_DISPENSE: begin
                    r_coin_reject <= coin_valid;
                    r_credit      <= '0;
                    r_code        <= '0;
                    r_count       <= '0;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                S_REFUND: begin
                    r_coin_reject <= coin_valid;
                    r_credit      <= '0;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign vm_code        = r_code;
    assign vm_count       = r_count;
    assign vm_money       = r_credit;
    assign coin_reject    = r_coin_reject;
    assign sel_fail       = r_sel_fail;
    assign dispense_valid = r_disp_valid;
    assign dispense_code  = r_disp_code;
    assign dispense_count = r_disp_count;
    assign change_valid   = r_change_valid;
    assign change         = r_change;
    assign busy           = r_busy;

endmodule
